// File: rtl/hilo_div_unit_pkg.sv
// Shared CPU definitions: divider FSM states, default width, DIV/DIVU funct codes.
// Latency: n/a (type and constant declarations only).
// Backpressure: n/a.
package cpu_defs;

    localparam int DIV_WIDTH = 32;

    // SPECIAL-opcode funct fields recognised by the decoder
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One combinational radix-2 restoring division iteration on unsigned magnitudes.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
//  rem/quo  : partial remainder and quotient before this step
//  dvs      : divisor magnitude
//  rem_nxt/quo_nxt : values after shifting {rem,quo} left and trying a subtract
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic             unused_trial;

    // The shifted remainder needs WIDTH+1 bits; one extra bit holds the borrow.
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign trial     = {1'b0, rem_sh} - {2'b00, dvs};
    assign trial_neg = trial[WIDTH+1];

    // A successful trial is always below dvs, so its top magnitude bit is zero.
    assign unused_trial = trial[WIDTH];

    assign rem_nxt = trial_neg ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~trial_neg};

endmodule

// File: rtl/hilo_div_unit.sv
// DIV/DIVU engine writing quotient to LO and remainder to HI.
// Latency: fixed; start accepted at edge N gives done in the cycle after edge N+WIDTH+1.
// Backpressure: busy holds the EX stage; start is ignored unless the FSM is idle.
//  clk, rst                       : clock and synchronous active-high reset
//  start, is_signed, dividend, divisor : request and operands, captured in IDLE
//  busy, done                     : in-progress flag and one-cycle completion pulse
//  lo_data/hi_data, lo_we/hi_we   : results (held) and write-enable pulses
module hilo_div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo_data,
    output logic [WIDTH-1:0] hi_data,
    output logic             lo_we,
    output logic             hi_we
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             dvz;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Negating the most negative value returns the same pattern, which is
    // already the correct unsigned magnitude.
    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dvs     (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DIV_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            lo_we   <= 1'b0;
            hi_we   <= 1'b0;
            lo_data <= '0;
            hi_data <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dvz     <= 1'b0;
        end else begin
            done  <= 1'b0;
            lo_we <= 1'b0;
            hi_we <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        rem    <= '0;
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        dvz    <= (divisor == '0);
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DIV_FIN;
                    end
                end
                DIV_FIN: begin
                    // A zero divisor leaves rem equal to |dividend|, so sign
                    // correction already restores hi = dividend; only LO needs
                    // forcing to all ones regardless of signs.
                    lo_data <= dvz ? '1 : (sign_q ? -quo : quo);
                    hi_data <= sign_r ? -rem : rem;
                    done    <= 1'b1;
                    lo_we   <= 1'b1;
                    hi_we   <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DIV_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit (WIDTH=32) with immediate-assertion checks.
// Latency: expects done exactly WIDTH+1 sample cycles after the accept edge.
// Backpressure: exercises start while busy and start held continuously.
module tb_hilo_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] lo_data;
    logic [W-1:0] hi_data;
    logic         lo_we;
    logic         hi_we;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int overlap  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    hilo_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .lo_data   (lo_data),
        .hi_data   (hi_data),
        .lo_we     (lo_we),
        .hi_we     (hi_we)
    );

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && busy) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one division and wait for done; checks latency, busy length,
    // the single-cycle pulse and the results. inject pulses a stray start
    // (9/4) on busy cycle 3.
    task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_lo,
                           input logic [W-1:0] exp_hi, input bit inject);
        int lat;
        int bcnt;
        int d0;
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        d0   = done_cnt;
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            if (inject && lat == 2) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, W + 1);
        check({tag, " busy_cycles"}, bcnt, W + 1);
        check({tag, " lo"}, lo_data, exp_lo);
        check({tag, " hi"}, hi_data, exp_hi);
        check({tag, " we"}, {30'd0, lo_we, hi_we}, 32'd3);
        @(negedge clk);
        check({tag, " pulse_end"}, {29'd0, done, lo_we, hi_we}, 32'd0);
        check({tag, " held_lo"}, lo_data, exp_lo);
        if (inject) begin
            repeat (W + 4) @(negedge clk);
            check({tag, " single_done"}, done_cnt - d0, 1);
        end
    endtask

    initial begin
        int d0;
        int t_prev;
        int t_cur;
        int ndone;
        int guard;

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset busy_done", {30'd0, busy, done}, 32'd0);
        check("reset we", {30'd0, lo_we, hi_we}, 32'd0);
        check("reset lo", lo_data, 32'd0);
        check("reset hi", hi_data, 32'd0);
        rst = 1'b0;

        // 1: basic unsigned
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        // 2: signed truncation toward zero, remainder follows dividend
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0);
        // 3: divide by zero and signed overflow
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
        // 4: max unsigned, with a stray start during busy
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b1);

        // 5: reset during CALC cycle 10
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort lo", lo_data, 32'd0);
        check("abort hi", hi_data, 32'd0);
        repeat (2 * W) @(negedge clk);
        check("abort no_done", done_cnt - d0, 0);
        run_div("after_abort_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

        // 6: start held high; expect one division every WIDTH+2 cycles
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        ndone = 0; t_prev = 0; guard = 0;
        while (ndone < 3 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (done) begin
                t_cur = cyc;
                check("b2b lo", lo_data, 32'd14);
                check("b2b hi", hi_data, 32'd2);
                if (ndone > 0) check("b2b period", t_cur - t_prev, W + 2);
                t_prev = t_cur;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b count", ndone, 3);
        repeat (W + 4) @(negedge clk);
        check("done_busy_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
